// File: rtl/gpu_bg_block_xfer.sv
// gpu_bg_block_xfer
//   Moves one 16-pixel background block between the pixel backend and
//   memory. A "subsequent" block step first writes the finished block back
//   (masked, 64-bit beats). When blending needs it, the next block is then
//   loaded and handed to the backend.
//
// Ports
//   clk, i_rst              rising-edge clock, asynchronous active-high reset
//   i_blockStep[1:0]        00 none, 01 first block, 10/11 subsequent block
//   i_doBlockOp             level request; only its 0->1 edge starts an operation
//   i_noblend               1 = skip the background load
//   i_loadAdr, i_saveAdr    block addresses {Y[8:0], X[9:4]}
//   i_saveBlock, i_saveMask pixels to write back (pixel n at [16n+15:16n]) and per-pixel write mask
//   o_busy                  operation in progress
//   o_importPulse           one-cycle strobe: o_importBlock holds a fresh load
//   o_importBlock           last loaded block (held between loads)
//   o_opDone                one-cycle strobe at the end of every accepted operation
//   o_overrun               sticky: a request edge arrived while busy
//   o_memCmd*               command channel (valid/ready, write, word address, data, byte enables)
//   i_memRValid, i_memRData in-order read data, one 64-bit beat per valid
module gpu_bg_block_xfer (
    input  logic         clk,
    input  logic         i_rst,
    input  logic [1:0]   i_blockStep,
    input  logic         i_doBlockOp,
    input  logic         i_noblend,
    input  logic [14:0]  i_loadAdr,
    input  logic [14:0]  i_saveAdr,
    input  logic [255:0] i_saveBlock,
    input  logic [15:0]  i_saveMask,
    output logic         o_busy,
    output logic         o_importPulse,
    output logic [255:0] o_importBlock,
    output logic         o_opDone,
    output logic         o_overrun,
    output logic         o_memCmdValid,
    input  logic         i_memCmdReady,
    output logic         o_memCmdWrite,
    output logic [16:0]  o_memAdr,
    output logic [63:0]  o_memWData,
    output logic [7:0]   o_memByteEn,
    input  logic         i_memRValid,
    input  logic [63:0]  i_memRData
);

    typedef enum logic [2:0] {IDLE, WRITE, READ_CMD, READ_WAIT, DONE} state_t;

    state_t         state;
    logic           doBlockOpQ;
    logic           noblendQ;
    logic [14:0]    loadAdrQ;
    logic [14:0]    saveAdrQ;
    logic [255:0]   saveBlockQ;
    logic [15:0]    saveMaskQ;
    logic [1:0]     beat;
    logic [1:0]     rspCnt;
    logic [191:0]   readBuf;     // first three returned beats, newest on top

    logic           trigger;
    logic [3:0]     beatMask;

    assign trigger  = i_doBlockOp & ~doBlockOpQ;
    assign beatMask = saveMaskQ[{beat, 2'b00} +: 4];

    // Each pixel mask bit enables both bytes of its 16-bit pixel.
    function automatic logic [7:0] expandMask(input logic [3:0] m);
        return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
    endfunction

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            doBlockOpQ    <= 1'b0;
            noblendQ      <= 1'b0;
            loadAdrQ      <= '0;
            saveAdrQ      <= '0;
            saveBlockQ    <= '0;
            saveMaskQ     <= '0;
            beat          <= '0;
            rspCnt        <= '0;
            readBuf       <= '0;
            o_busy        <= 1'b0;
            o_importPulse <= 1'b0;
            o_importBlock <= '0;
            o_opDone      <= 1'b0;
            o_overrun     <= 1'b0;
            o_memCmdValid <= 1'b0;
            o_memCmdWrite <= 1'b0;
            o_memAdr      <= '0;
            o_memWData    <= '0;
            o_memByteEn   <= '0;
        end else begin
            doBlockOpQ    <= i_doBlockOp;
            o_importPulse <= 1'b0;
            o_opDone      <= 1'b0;

            if (trigger && o_busy)
                o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (trigger && i_blockStep != 2'b00) begin
                        noblendQ   <= i_noblend;
                        loadAdrQ   <= i_loadAdr;
                        saveAdrQ   <= i_saveAdr;
                        saveBlockQ <= i_saveBlock;
                        saveMaskQ  <= i_saveMask;
                        beat       <= '0;
                        o_busy     <= 1'b1;
                        if (i_blockStep == 2'b01)
                            state <= i_noblend ? DONE : READ_CMD;
                        else
                            state <= WRITE;
                    end
                end

                // One beat is examined per idle cycle; a fully masked beat is
                // stepped over without touching the command channel.
                WRITE: begin
                    if (!o_memCmdValid) begin
                        if (beatMask != 4'b0000) begin
                            o_memCmdValid <= 1'b1;
                            o_memCmdWrite <= 1'b1;
                            o_memAdr      <= {saveAdrQ, beat};
                            o_memWData    <= saveBlockQ[{beat, 6'b000000} +: 64];
                            o_memByteEn   <= expandMask(beatMask);
                        end else if (beat == 2'd3) begin
                            beat  <= '0;
                            state <= noblendQ ? DONE : READ_CMD;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end else if (i_memCmdReady) begin
                        o_memCmdValid <= 1'b0;
                        if (beat == 2'd3) begin
                            beat  <= '0;
                            state <= noblendQ ? DONE : READ_CMD;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end

                // Read commands go out back to back while ready stays high.
                READ_CMD: begin
                    if (!o_memCmdValid) begin
                        o_memCmdValid <= 1'b1;
                        o_memCmdWrite <= 1'b0;
                        o_memAdr      <= {loadAdrQ, beat};
                        o_memByteEn   <= '0;
                    end else if (i_memCmdReady) begin
                        if (beat == 2'd3) begin
                            o_memCmdValid <= 1'b0;
                            beat          <= '0;
                            state         <= READ_WAIT;
                        end else begin
                            beat     <= beat + 2'd1;
                            o_memAdr <= {loadAdrQ, beat + 2'd1};
                        end
                    end
                end

                READ_WAIT: begin
                end

                DONE: begin
                    o_opDone <= 1'b1;
                    o_busy   <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase

            // Read data is only meaningful while a load is outstanding; the
            // fourth beat completes the block and overrides the state update.
            if ((state == READ_CMD || state == READ_WAIT) && i_memRValid) begin
                rspCnt <= rspCnt + 2'd1;
                if (rspCnt == 2'd3) begin
                    o_importBlock <= {i_memRData, readBuf};
                    o_importPulse <= 1'b1;
                    o_opDone      <= 1'b1;
                    o_busy        <= 1'b0;
                    o_memCmdValid <= 1'b0;
                    beat          <= '0;
                    state         <= IDLE;
                end else begin
                    readBuf <= {i_memRData, readBuf[191:64]};
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_bg_block_xfer.sv
module tb_gpu_bg_block_xfer;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [1:0]   i_blockStep;
    logic         i_doBlockOp;
    logic         i_noblend;
    logic [14:0]  i_loadAdr;
    logic [14:0]  i_saveAdr;
    logic [255:0] i_saveBlock;
    logic [15:0]  i_saveMask;
    logic         o_busy;
    logic         o_importPulse;
    logic [255:0] o_importBlock;
    logic         o_opDone;
    logic         o_overrun;
    logic         o_memCmdValid;
    logic         i_memCmdReady;
    logic         o_memCmdWrite;
    logic [16:0]  o_memAdr;
    logic [63:0]  o_memWData;
    logic [7:0]   o_memByteEn;
    logic         i_memRValid;
    logic [63:0]  i_memRData;

    always #5 clk = ~clk;

    gpu_bg_block_xfer dut (
        .clk(clk), .i_rst(i_rst), .i_blockStep(i_blockStep), .i_doBlockOp(i_doBlockOp),
        .i_noblend(i_noblend), .i_loadAdr(i_loadAdr), .i_saveAdr(i_saveAdr),
        .i_saveBlock(i_saveBlock), .i_saveMask(i_saveMask), .o_busy(o_busy),
        .o_importPulse(o_importPulse), .o_importBlock(o_importBlock), .o_opDone(o_opDone),
        .o_overrun(o_overrun), .o_memCmdValid(o_memCmdValid), .i_memCmdReady(i_memCmdReady),
        .o_memCmdWrite(o_memCmdWrite), .o_memAdr(o_memAdr), .o_memWData(o_memWData),
        .o_memByteEn(o_memByteEn), .i_memRValid(i_memRValid), .i_memRData(i_memRData)
    );

    typedef struct {
        logic        wr;
        logic [16:0] adr;
        logic [63:0] d;
        logic [7:0]  en;
    } cmd_t;

    cmd_t         cmdQ[$];
    logic [255:0] impQ[$];
    logic [63:0]  respQ[$];

    int nChecks = 0;
    int nFail = 0;
    int opDoneCnt = 0;
    int importCnt = 0;
    int cmdCnt = 0;
    int rspDelivered = 0;
    int holdAfter = 1 << 30;
    int readyMode = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] memData(input logic [16:0] a);
        return {8'hD0, 7'h00, a, 15'h0000, a};
    endfunction

    function automatic logic [7:0] pixMaskToBytes(input logic [3:0] m);
        logic [7:0] en;
        for (int j = 0; j < 4; j++) begin
            en[2*j]   = m[j];
            en[2*j+1] = m[j];
        end
        return en;
    endfunction

    function automatic logic [255:0] randBlock();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Memory model, ready driver and output monitor
    initial begin : monitor
        cmd_t        e;
        logic        pendValid;
        logic        pendWr;
        logic [16:0] pendAdr;
        logic [63:0] pendD;
        logic [7:0]  pendEn;
        pendValid = 1'b0;
        pendWr = 1'b0; pendAdr = '0; pendD = '0; pendEn = '0;
        i_memCmdReady = 1'b1;
        i_memRValid = 1'b0;
        i_memRData = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                pendValid = 1'b0;
                i_memRValid = 1'b0;
                continue;
            end
            if (respQ.size() > 0 && rspDelivered < holdAfter && $urandom_range(0, 3) != 0) begin
                i_memRValid = 1'b1;
                i_memRData = respQ.pop_front();
                rspDelivered++;
            end else begin
                i_memRValid = 1'b0;
                i_memRData = {$urandom, $urandom};
            end
            case (readyMode)
                0: i_memCmdReady = 1'b1;
                1: i_memCmdReady = ~i_memCmdReady;
                default: i_memCmdReady = 1'($urandom_range(0, 1));
            endcase
            if (pendValid) begin
                check("cmdHeldValid", o_memCmdValid, 1'b1);
                check("cmdHeldWrite", o_memCmdWrite, pendWr);
                check("cmdHeldAdr", o_memAdr, pendAdr);
                check("cmdHeldData", o_memWData, pendD);
                check("cmdHeldByteEn", o_memByteEn, pendEn);
            end
            pendValid = o_memCmdValid && !i_memCmdReady;
            pendWr = o_memCmdWrite; pendAdr = o_memAdr; pendD = o_memWData; pendEn = o_memByteEn;
            if (o_memCmdValid && i_memCmdReady) begin
                cmdCnt++;
                check("cmdExpected", cmdQ.size() > 0, 1'b1);
                if (cmdQ.size() > 0) begin
                    e = cmdQ.pop_front();
                    check("cmdWrite", o_memCmdWrite, e.wr);
                    check("cmdAdr", o_memAdr, e.adr);
                    if (e.wr) begin
                        check("cmdWData", o_memWData, e.d);
                        check("cmdByteEn", o_memByteEn, e.en);
                    end
                end
                if (!o_memCmdWrite) respQ.push_back(memData(o_memAdr));
            end
            if (o_importPulse) begin
                importCnt++;
                check("importExpected", impQ.size() > 0, 1'b1);
                if (impQ.size() > 0) check("importBlock", o_importBlock, impQ.pop_front());
                check("busyLowAtPulse", o_busy, 1'b0);
                check("opDoneWithPulse", o_opDone, 1'b1);
            end
            if (o_opDone) opDoneCnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startOp(input logic [1:0] step, input logic nb, input logic [14:0] la,
                           input logic [14:0] sa, input logic [255:0] blk, input logic [15:0] msk);
        cmd_t c;
        logic [1:0] kb;
        i_doBlockOp = 1'b0;
        @(negedge clk);
        i_blockStep = step; i_noblend = nb; i_loadAdr = la; i_saveAdr = sa;
        i_saveBlock = blk; i_saveMask = msk;
        if (step != 2'b00) begin
            if (step != 2'b01) begin
                for (int k = 0; k < 4; k++) begin
                    kb = k[1:0];
                    if (msk[4*k +: 4] != 4'b0000) begin
                        c.wr = 1'b1; c.adr = {sa, kb}; c.d = blk[64*k +: 64];
                        c.en = pixMaskToBytes(msk[4*k +: 4]);
                        cmdQ.push_back(c);
                    end
                end
            end
            if (!nb) begin
                for (int k = 0; k < 4; k++) begin
                    kb = k[1:0];
                    c.wr = 1'b0; c.adr = {la, kb}; c.d = '0; c.en = '0;
                    cmdQ.push_back(c);
                end
                impQ.push_back({memData({la, 2'd3}), memData({la, 2'd2}),
                                memData({la, 2'd1}), memData({la, 2'd0})});
            end
        end
        i_doBlockOp = 1'b1;
        @(negedge clk);
        check("busyAfterTrigger", o_busy, step != 2'b00);
    endtask

    task automatic waitDone(input string tag, input int startDone);
        int n = 0;
        while (opDoneCnt == startDone && n < 400) begin
            @(negedge clk);
            n++;
        end
        cycles(3);
        check({tag, "_opDoneCount"}, opDoneCnt - startDone, 1);
        check({tag, "_cmdLeft"}, cmdQ.size(), 0);
        check({tag, "_importLeft"}, impQ.size(), 0);
        check({tag, "_busyAfter"}, o_busy, 1'b0);
    endtask

    task automatic runOp(input string tag, input logic [1:0] step, input logic nb, input logic [14:0] la,
                         input logic [14:0] sa, input logic [255:0] blk, input logic [15:0] msk);
        int s = opDoneCnt;
        startOp(step, nb, la, sa, blk, msk);
        waitDone(tag, s);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_importPulse"}, o_importPulse, 1'b0);
        check({tag, "_opDone"}, o_opDone, 1'b0);
        check({tag, "_overrun"}, o_overrun, 1'b0);
        check({tag, "_cmdValid"}, o_memCmdValid, 1'b0);
        check({tag, "_importBlock"}, o_importBlock, 256'h0);
        check({tag, "_memAdr"}, o_memAdr, 17'h0);
        check({tag, "_memWData"}, o_memWData, 64'h0);
        check({tag, "_memByteEn"}, o_memByteEn, 8'h0);
    endtask

    initial begin : stimulus
        int s;
        int c0;
        int i0;
        int n;
        logic [1:0] st;
        logic [15:0] m;
        i_rst = 1'b1; i_blockStep = 2'b00; i_doBlockOp = 1'b0; i_noblend = 1'b0;
        i_loadAdr = '0; i_saveAdr = '0; i_saveBlock = '0; i_saveMask = '0;
        cycles(3);
        checkIdleOutputs("reset");
        i_rst = 1'b0;
        cycles(2);
        checkIdleOutputs("afterReset");

        // first block, load only
        readyMode = 0;
        runOp("firstLoad", 2'b01, 1'b0, 15'h1234, 15'h7FFF, randBlock(), 16'hFFFF);

        // subsequent block, one write beat, no load
        i0 = importCnt;
        runOp("singleWrite", 2'b10, 1'b1, 15'h0ABC, 15'h0001, randBlock(), 16'h00F0);
        check("singleWrite_noImport", importCnt - i0, 0);

        // sparse mask with stalling ready, then load
        readyMode = 1;
        runOp("sparseWrite", 2'b10, 1'b0, 15'h2222, 15'h3333, randBlock(), 16'h8001);
        readyMode = 0;

        // step 00 is ignored
        s = opDoneCnt; c0 = cmdCnt;
        startOp(2'b00, 1'b0, 15'h0100, 15'h0200, randBlock(), 16'hFFFF);
        cycles(20);
        check("stepNone_opDone", opDoneCnt - s, 0);
        check("stepNone_cmds", cmdCnt - c0, 0);
        check("stepNone_busy", o_busy, 1'b0);

        // request held high: one operation only
        s = opDoneCnt;
        startOp(2'b10, 1'b1, 15'h0010, 15'h0020, randBlock(), 16'h0F0F);
        cycles(50);
        check("heldReq_opDone", opDoneCnt - s, 1);
        check("heldReq_cmdLeft", cmdQ.size(), 0);
        check("heldReq_overrun", o_overrun, 1'b0);
        i_doBlockOp = 1'b0;

        // randomized operations with random ready
        readyMode = 2;
        for (int t = 0; t < 8; t++) begin
            st = 2'($urandom_range(1, 3));
            m = (t == 3) ? 16'h0000 : 16'($urandom);
            runOp("random", st, 1'($urandom_range(0, 1)), 15'($urandom), 15'($urandom), randBlock(), m);
        end
        readyMode = 0;

        // second request during READ_WAIT
        holdAfter = rspDelivered;
        s = opDoneCnt;
        startOp(2'b01, 1'b0, 15'h1111, 15'h0000, randBlock(), 16'h0000);
        n = 0;
        while (cmdQ.size() > 0 && n < 50) begin @(negedge clk); n++; end
        cycles(3);
        check("overrun_busyWaiting", o_busy, 1'b1);
        i_doBlockOp = 1'b0; i_loadAdr = 15'h7777; i_blockStep = 2'b10; i_saveMask = 16'hFFFF;
        cycles(1);
        i_doBlockOp = 1'b1;
        cycles(2);
        check("overrun_set", o_overrun, 1'b1);
        holdAfter = 1 << 30;
        waitDone("overrun", s);
        check("overrun_sticky", o_overrun, 1'b1);
        i_doBlockOp = 1'b0;

        // reset in the middle of a load, stale data afterwards
        holdAfter = rspDelivered + 2;
        s = opDoneCnt; i0 = importCnt;
        startOp(2'b01, 1'b0, 15'h0555, 15'h0000, randBlock(), 16'h0000);
        i_doBlockOp = 1'b0;
        n = 0;
        while (!(rspDelivered >= holdAfter && cmdQ.size() == 0) && n < 100) begin @(negedge clk); n++; end
        cycles(2);
        i_rst = 1'b1;
        cycles(2);
        check("midReset_busy", o_busy, 1'b0);
        check("midReset_cmdValid", o_memCmdValid, 1'b0);
        i_rst = 1'b0;
        cmdQ.delete();
        impQ.delete();
        while (respQ.size() > 2) void'(respQ.pop_back());
        while (respQ.size() < 2) respQ.push_back({$urandom, $urandom});
        holdAfter = 1 << 30;
        cycles(15);
        check("stale_delivered", respQ.size(), 0);
        check("stale_opDone", opDoneCnt - s, 0);
        check("stale_import", importCnt - i0, 0);
        check("stale_importBlock", o_importBlock, 256'h0);
        check("stale_overrunCleared", o_overrun, 1'b0);
        check("stale_busy", o_busy, 1'b0);

        runOp("afterReset", 2'b10, 1'b0, 15'h4321, 15'h1357, randBlock(), 16'hF00F);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
